// File: rtl/retire_trace_if.sv
// Signals between the writeback stage, the retirement-trace generator and the
// trace sink: the retire bundle in, back-pressure out, and the record stream.
interface retire_trace_if #(
  parameter int CNT_W = 32
);
  logic             commit_valid;
  logic [15:0]      commit_pc;
  logic [15:0]      commit_inst;
  logic             reg_write;
  logic [2:0]       write_reg;
  logic [15:0]      write_data;
  logic             mem_read;
  logic             mem_write;
  logic [15:0]      mem_addr;
  logic [15:0]      mem_data;
  logic             halt;
  logic             stall;
  logic             rec_valid;
  logic             rec_ready;
  logic [2:0]       rec_kind;
  logic [CNT_W-1:0] rec_inum;
  logic [CNT_W-1:0] rec_cycle;
  logic [15:0]      rec_pc;
  logic [15:0]      rec_inst;
  logic [2:0]       rec_reg;
  logic [15:0]      rec_rval;
  logic [15:0]      rec_addr;
  logic [15:0]      rec_mval;
  logic             done;

  modport master (
    input  commit_valid, commit_pc, commit_inst, reg_write, write_reg, write_data,
           mem_read, mem_write, mem_addr, mem_data, halt, rec_ready,
    output stall, rec_valid, rec_kind, rec_inum, rec_cycle, rec_pc, rec_inst,
           rec_reg, rec_rval, rec_addr, rec_mval, done
  );

  modport slave (
    output commit_valid, commit_pc, commit_inst, reg_write, write_reg, write_data,
           mem_read, mem_write, mem_addr, mem_data, halt, rec_ready,
    input  stall, rec_valid, rec_kind, rec_inum, rec_cycle, rec_pc, rec_inst,
           rec_reg, rec_rval, rec_addr, rec_mval, done
  );
endinterface

// File: rtl/retire_trace_gen.sv
// Retirement-trace producer: classifies each retired instruction into a trace
// record, queues it in a small in-order FIFO and streams it to a trace sink.
module retire_trace_gen #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  retire_trace_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    KIND_NOP  = 3'd0,
    KIND_REG  = 3'd1,
    KIND_LD   = 3'd2,
    KIND_ST   = 3'd3,
    KIND_STU  = 3'd4,
    KIND_HALT = 3'd5
  } kind_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    kind_e            kind;
    logic [CNT_W-1:0] inum;
    logic [CNT_W-1:0] cycle;
    logic [15:0]      pc;
    logic [15:0]      inst;
    logic [2:0]       regNum;
    logic [15:0]      rval;
    logic [15:0]      addr;
    logic [15:0]      mval;
  } rec_t;

  rec_t             newRec;
  rec_t             headRec;
  rec_t             fifoMem [DEPTH];
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [CNT_W-1:0] instCnt;
  logic [CNT_W-1:0] cycleCnt;
  state_e           state;
  state_e           stateNxt;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             stallInt;
  logic             accept;
  logic             pop;

  // Occupancy flags come straight from the registered pointers, so stall and
  // the record stream never depend combinationally on the commit inputs.
  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign stallInt  = fifoFull || (state != ST_RUN);
  assign accept    = bus.commit_valid && !stallInt;
  assign pop       = !fifoEmpty && bus.rec_ready;

  // Classification in priority order; fields not belonging to the kind stay 0.
  always_comb begin
    newRec       = '0;
    newRec.inum  = instCnt;
    newRec.cycle = cycleCnt;
    newRec.pc    = bus.commit_pc;
    newRec.inst  = bus.commit_inst;
    if (bus.halt) begin
      newRec.kind = KIND_HALT;
    end else if (bus.reg_write && bus.mem_write) begin
      newRec.kind   = KIND_STU;
      newRec.regNum = bus.write_reg;
      newRec.rval   = bus.write_data;
      newRec.addr   = bus.mem_addr;
      newRec.mval   = bus.mem_data;
    end else if (bus.reg_write && bus.mem_read) begin
      newRec.kind   = KIND_LD;
      newRec.regNum = bus.write_reg;
      newRec.rval   = bus.write_data;
      newRec.addr   = bus.mem_addr;
    end else if (bus.reg_write) begin
      newRec.kind   = KIND_REG;
      newRec.regNum = bus.write_reg;
      newRec.rval   = bus.write_data;
    end else if (bus.mem_write) begin
      newRec.kind = KIND_ST;
      newRec.addr = bus.mem_addr;
      newRec.mval = bus.mem_data;
    end else begin
      newRec.kind = KIND_NOP;
    end
  end

  // Record storage: data only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (accept) begin
      fifoMem[wrPtr[AW-1:0]] <= newRec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      instCnt  <= '0;
      cycleCnt <= '0;
    end else begin
      cycleCnt <= cycleCnt + CNT_ONE;
      if (accept) begin
        wrPtr   <= wrPtr + PTR_ONE;
        instCnt <= instCnt + CNT_ONE;
      end
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= stateNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      ST_RUN:   if (accept && bus.halt) stateNxt = ST_DRAIN;
      ST_DRAIN: if (fifoEmpty) stateNxt = ST_DONE;
      ST_DONE:  stateNxt = ST_DONE;
      default:  stateNxt = ST_RUN;
    endcase
  end

  // An empty FIFO presents an all-zero record, which also covers reset.
  always_comb begin
    headRec = '0;
    if (!fifoEmpty) begin
      headRec = fifoMem[rdPtr[AW-1:0]];
    end
  end

  assign bus.stall     = stallInt;
  assign bus.rec_valid = !fifoEmpty;
  assign bus.rec_kind  = headRec.kind;
  assign bus.rec_inum  = headRec.inum;
  assign bus.rec_cycle = headRec.cycle;
  assign bus.rec_pc    = headRec.pc;
  assign bus.rec_inst  = headRec.inst;
  assign bus.rec_reg   = headRec.regNum;
  assign bus.rec_rval  = headRec.rval;
  assign bus.rec_addr  = headRec.addr;
  assign bus.rec_mval  = headRec.mval;
  // Done is visible as soon as the halt record has left, while the state
  // register itself moves to DONE one edge later on the registered empty flag.
  assign bus.done      = (state == ST_DONE) || ((state == ST_DRAIN) && fifoEmpty);
endmodule

// File: tb/tb_retire_trace_gen.sv
// Bench for retire_trace_gen: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based trace model.
module tb_retire_trace_gen;
  localparam int DEPTH = 4;

  typedef struct {
    logic [2:0]  kind;
    logic [31:0] inum;
    logic [31:0] cycle;
    logic [15:0] pc;
    logic [15:0] inst;
    logic [2:0]  rg;
    logic [15:0] rval;
    logic [15:0] addr;
    logic [15:0] mval;
  } trec_t;

  logic clk = 1'b0;
  logic rst;
  int   nCompared = 0;
  int   nMismatch = 0;

  always #5 clk = ~clk;

  retire_trace_if #(.CNT_W(32)) bus ();
  retire_trace_gen #(.DEPTH(DEPTH), .CNT_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Reference model state
  trec_t       q[$];
  trec_t       popped;
  trec_t       expHead;
  logic [31:0] mInst;
  logic [31:0] mCycle;
  bit          mHalted;
  bit          mDone;
  bit          mLive = 0;
  bit          mAcc;
  bit          mStall;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic trec_t classify(input logic hlt, input logic rw, input logic mr,
                                     input logic mw, input logic [2:0] wr,
                                     input logic [15:0] wd, input logic [15:0] ma,
                                     input logic [15:0] md, input logic [15:0] pc,
                                     input logic [15:0] inst, input logic [31:0] inum,
                                     input logic [31:0] cyc);
    trec_t r;
    int k;
    if (hlt) k = 5;
    else if (rw && mw) k = 4;
    else if (rw && mr) k = 2;
    else if (rw) k = 1;
    else if (mw) k = 3;
    else k = 0;
    r.kind  = 3'(k);
    r.inum  = inum;
    r.cycle = cyc;
    r.pc    = pc;
    r.inst  = inst;
    r.rg    = (k inside {1, 2, 4}) ? wr : 3'd0;
    r.rval  = (k inside {1, 2, 4}) ? wd : 16'd0;
    r.addr  = (k inside {2, 3, 4}) ? ma : 16'd0;
    r.mval  = (k inside {3, 4}) ? md : 16'd0;
    return r;
  endfunction

  // Model update on every rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        mInst = 0; mCycle = 0; mHalted = 0; mDone = 0; mLive = 1;
      end else if (mLive) begin
        mStall = (q.size() >= DEPTH) || mHalted;
        mAcc   = bus.commit_valid && !mStall;
        if (q.size() > 0 && bus.rec_ready) begin
          popped = q.pop_front();
          if (popped.kind == 3'd5) mDone = 1;
        end
        if (mAcc) begin
          q.push_back(classify(bus.halt, bus.reg_write, bus.mem_read, bus.mem_write,
                               bus.write_reg, bus.write_data, bus.mem_addr, bus.mem_data,
                               bus.commit_pc, bus.commit_inst, mInst, mCycle));
          mInst = mInst + 1;
          if (bus.halt) mHalted = 1;
        end
        mCycle = mCycle + 1;
      end
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (mLive) begin
        if (q.size() > 0) expHead = q[0];
        else expHead = '{default: '0};
        check("stall", 64'(bus.stall), 64'((q.size() >= DEPTH) || mHalted));
        check("rec_valid", 64'(bus.rec_valid), 64'(q.size() > 0));
        check("done", 64'(bus.done), 64'(mDone));
        check("rec_kind", 64'(bus.rec_kind), 64'(expHead.kind));
        check("rec_inum", 64'(bus.rec_inum), 64'(expHead.inum));
        check("rec_cycle", 64'(bus.rec_cycle), 64'(expHead.cycle));
        check("rec_pc", 64'(bus.rec_pc), 64'(expHead.pc));
        check("rec_inst", 64'(bus.rec_inst), 64'(expHead.inst));
        check("rec_reg", 64'(bus.rec_reg), 64'(expHead.rg));
        check("rec_rval", 64'(bus.rec_rval), 64'(expHead.rval));
        check("rec_addr", 64'(bus.rec_addr), 64'(expHead.addr));
        check("rec_mval", 64'(bus.rec_mval), 64'(expHead.mval));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [15:0] pc, input logic [15:0] inst,
                       input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                       input logic mr, input logic mw, input logic [15:0] ma,
                       input logic [15:0] md, input logic h);
    bus.commit_valid = v;
    bus.commit_pc    = pc;
    bus.commit_inst  = inst;
    bus.reg_write    = rw;
    bus.write_reg    = wr;
    bus.write_data   = wd;
    bus.mem_read     = mr;
    bus.mem_write    = mw;
    bus.mem_addr     = ma;
    bus.mem_data     = md;
    bus.halt         = h;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic driveReg(input int i);
    drive(1'b1, 16'(256 + 2 * i), 16'h1000, 1'b1, 3'(i), 16'(i), 1'b0, 1'b0,
          16'h0, 16'h0, 1'b0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] got[$];
  int          sent;
  bit          accNow;

  initial begin
    rst = 1'b1;
    idle();
    bus.rec_ready = 1'b0;
    repeat (2) step();
    check("reset_valid", 64'(bus.rec_valid), 64'd0);
    check("reset_stall", 64'(bus.stall), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_inum", 64'(bus.rec_inum), 64'd0);
    check("reset_rval", 64'(bus.rec_rval), 64'd0);

    // Single REG commit right after reset
    rst = 1'b0;
    bus.rec_ready = 1'b1;
    drive(1'b1, 16'h0010, 16'h7123, 1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    step();
    idle();
    check("reg_valid", 64'(bus.rec_valid), 64'd1);
    check("reg_kind", 64'(bus.rec_kind), 64'd1);
    check("reg_inum", 64'(bus.rec_inum), 64'd0);
    check("reg_cycle", 64'(bus.rec_cycle), 64'd0);
    check("reg_reg", 64'(bus.rec_reg), 64'd3);
    check("reg_rval", 64'(bus.rec_rval), 64'h1234);
    check("reg_addr", 64'(bus.rec_addr), 64'd0);
    check("reg_mval", 64'(bus.rec_mval), 64'd0);
    check("reg_pc", 64'(bus.rec_pc), 64'h0010);

    // Classification sweep
    doReset();
    bus.rec_ready = 1'b1;
    drive(1'b1, 16'h0020, 16'h4000, 1'b1, 3'd2, 16'hBEEF, 1'b1, 1'b0, 16'h0040, 16'h5555, 1'b0);
    step();
    check("ld_kind", 64'(bus.rec_kind), 64'd2);
    check("ld_inum", 64'(bus.rec_inum), 64'd0);
    check("ld_addr", 64'(bus.rec_addr), 64'h0040);
    check("ld_rval", 64'(bus.rec_rval), 64'hBEEF);
    check("ld_reg", 64'(bus.rec_reg), 64'd2);
    check("ld_mval", 64'(bus.rec_mval), 64'd0);
    drive(1'b1, 16'h0022, 16'h5000, 1'b0, 3'd5, 16'hAAAA, 1'b0, 1'b1, 16'h0042, 16'h0007, 1'b0);
    step();
    check("st_kind", 64'(bus.rec_kind), 64'd3);
    check("st_inum", 64'(bus.rec_inum), 64'd1);
    check("st_reg", 64'(bus.rec_reg), 64'd0);
    check("st_rval", 64'(bus.rec_rval), 64'd0);
    check("st_addr", 64'(bus.rec_addr), 64'h0042);
    check("st_mval", 64'(bus.rec_mval), 64'h0007);
    drive(1'b1, 16'h0024, 16'h6000, 1'b1, 3'd1, 16'h1111, 1'b0, 1'b1, 16'h0044, 16'h2222, 1'b0);
    step();
    check("stu_kind", 64'(bus.rec_kind), 64'd4);
    check("stu_inum", 64'(bus.rec_inum), 64'd2);
    check("stu_rval", 64'(bus.rec_rval), 64'h1111);
    check("stu_mval", 64'(bus.rec_mval), 64'h2222);
    drive(1'b1, 16'h0026, 16'hC000, 1'b0, 3'd6, 16'h3333, 1'b0, 1'b0, 16'h0046, 16'h4444, 1'b0);
    step();
    idle();
    check("br_kind", 64'(bus.rec_kind), 64'd0);
    check("br_inum", 64'(bus.rec_inum), 64'd3);
    check("br_fields", 64'({bus.rec_reg, bus.rec_rval, bus.rec_addr, bus.rec_mval}), 64'd0);

    // Backpressure: fill the FIFO with the sink stalled
    doReset();
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      driveReg(i);
      step();
    end
    check("bp_stall_full", 64'(bus.stall), 64'd1);
    driveReg(4);
    step();
    step();
    check("bp_stall_held", 64'(bus.stall), 64'd1);
    check("bp_head", 64'(bus.rec_inum), 64'd0);
    bus.rec_ready = 1'b1;
    sent = 4;
    got.delete();
    for (int cyc = 0; cyc < 40 && got.size() < 6; cyc++) begin
      if (sent < 6) driveReg(sent);
      else idle();
      accNow = (sent < 6) && !bus.stall;
      if (bus.rec_valid) got.push_back(bus.rec_inum);
      step();
      if (accNow) sent++;
    end
    idle();
    check("bp_count", 64'(got.size()), 64'd6);
    for (int i = 0; i < got.size(); i++) check("bp_order", 64'(got[i]), 64'(i));

    // Simultaneous push and pop at occupancy 1
    doReset();
    bus.rec_ready = 1'b0;
    driveReg(0);
    step();
    bus.rec_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      driveReg(i);
      step();
      check("pp_valid", 64'(bus.rec_valid), 64'd1);
      check("pp_stall", 64'(bus.stall), 64'd0);
      check("pp_inum", 64'(bus.rec_inum), 64'(i));
    end
    idle();
    bus.rec_ready = 1'b0;
    step();
    check("pp_hold_inum", 64'(bus.rec_inum), 64'd3);
    bus.rec_ready = 1'b1;
    step();
    check("pp_drained", 64'(bus.rec_valid), 64'd0);

    // Halt with two records pending
    doReset();
    bus.rec_ready = 1'b0;
    driveReg(0);
    step();
    driveReg(1);
    step();
    drive(1'b1, 16'h0030, 16'hF000, 1'b1, 3'd4, 16'h0009, 1'b0, 1'b1, 16'h0008, 16'h0009, 1'b1);
    step();
    check("halt_stall", 64'(bus.stall), 64'd1);
    driveReg(7);
    step();
    bus.rec_ready = 1'b1;
    check("halt_q0", 64'(bus.rec_inum), 64'd0);
    step();
    check("halt_q1", 64'(bus.rec_inum), 64'd1);
    step();
    check("halt_inum", 64'(bus.rec_inum), 64'd2);
    check("halt_kind", 64'(bus.rec_kind), 64'd5);
    check("halt_fields", 64'({bus.rec_reg, bus.rec_rval, bus.rec_addr, bus.rec_mval}), 64'd0);
    check("halt_done_pre", 64'(bus.done), 64'd0);
    step();
    check("halt_done", 64'(bus.done), 64'd1);
    check("halt_empty", 64'(bus.rec_valid), 64'd0);
    repeat (3) step();
    check("halt_done_sticky", 64'(bus.done), 64'd1);
    check("halt_stall_sticky", 64'(bus.stall), 64'd1);
    idle();

    // Reset with three records queued
    doReset();
    bus.rec_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      driveReg(i);
      step();
    end
    idle();
    check("mid_queued", 64'(bus.rec_valid), 64'd1);
    rst = 1'b1;
    step();
    check("mid_valid", 64'(bus.rec_valid), 64'd0);
    check("mid_stall", 64'(bus.stall), 64'd0);
    check("mid_done", 64'(bus.done), 64'd0);
    rst = 1'b0;
    bus.rec_ready = 1'b1;
    driveReg(5);
    step();
    idle();
    check("mid_inum", 64'(bus.rec_inum), 64'd0);
    check("mid_cycle", 64'(bus.rec_cycle), 64'd0);
    check("mid_rval", 64'(bus.rec_rval), 64'd5);

    // Randomized traffic, checked every cycle by the model
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if (mDone || $urandom_range(399) == 0) begin
        doReset();
      end else begin
        bus.rec_ready = ($urandom_range(9) < 6);
        if ($urandom_range(9) < 7)
          drive(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
                16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
                16'($urandom), ($urandom_range(99) == 0));
        else
          idle();
        step();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got t=%0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/retire_trace_gen.md
# retire_trace_gen

Synthesizable retirement-trace producer that sits at the writeback end of the processor pipeline. Each cycle it samples the retire bundle (PC, instruction, register write, memory access, halt) and classifies it into a trace record. It tags the record with a sequential instruction number and cycle stamp, buffers it in a small FIFO, and emits it over a valid/ready stream to a trace sink. It back-pressures the pipeline through `stall` and reports drain completion after halt.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 32: width of instruction and cycle counters.

Ports:
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `commit_valid` in 1: one instruction retires this cycle.
- `commit_pc` in 16: PC of retiring instruction.
- `commit_inst` in 16: instruction word.
- `reg_write` in 1: retiring instruction writes the register file.
- `write_reg` in 3: destination register.
- `write_data` in 16: register write value.
- `mem_read` in 1: load.
- `mem_write` in 1: store.
- `mem_addr` in 16: data memory address.
- `mem_data` in 16: store data.
- `halt` in 1: retiring instruction is HALT.
- `stall` out 1: FIFO full or not in RUN state; pipeline must hold the retire bundle.
- `rec_valid` out 1: record available.
- `rec_ready` in 1: sink accepts record.
- `rec_kind` out 3: 0 NOP/branch, 1 REG, 2 LD, 3 ST, 4 STU, 5 HALT.
- `rec_inum` out CNT_W: instruction number.
- `rec_cycle` out CNT_W: cycle stamp at acceptance.
- `rec_pc`, `rec_inst` out 16 each.
- `rec_reg` out 3, `rec_rval` out 16: register fields; 0 unless kind ∈ {1,2,4}.
- `rec_addr` out 16: 0 unless kind ∈ {2,3,4}.
- `rec_mval` out 16: 0 unless kind ∈ {3,4}.
- `done` out 1: halt record has been consumed; sticky until reset.

## Operation
- Classification uses priority order:
  - `halt` → HALT.
  - `reg_write & mem_write` → STU.
  - `reg_write & mem_read` → LD.
  - `reg_write` → REG.
  - `mem_write` → ST.
  - Otherwise → NOP.
  - Fields that do not apply to the kind are forced to 0.
- Accept condition: `commit_valid & ~stall`.
- On accept:
  - Push one record with `rec_inum` = the instruction counter.
  - Increment the instruction counter (wraps modulo 2^CNT_W).
- The cycle counter is 0 in the first cycle after reset deasserts and increments every cycle, wrapping.
- The FIFO is in-order.
  - Pop occurs when `rec_valid & rec_ready`.
  - Push is blocked when the FIFO is full, even if a pop happens in the same cycle. `stall` is a function of registered state only.
  - Simultaneous push and pop when the FIFO is neither full nor empty leaves occupancy unchanged.
- State machine:
  - RUN: normal operation. Accepting a HALT record → DRAIN.
  - DRAIN: `stall`=1 and commits are ignored. When the FIFO is empty → DONE.
  - DONE: `done`=1, `stall`=1. Exit only by `rst`.

## Timing
- Reset values:
  - `rec_valid`=0, `stall`=0, `done`=0.
  - All `rec_*` data outputs 0.
  - Both counters 0, FIFO empty, state RUN.
- Latency: a commit accepted at edge N has `rec_valid`=1 after edge N, one cycle later. Record outputs are driven from registered storage; there is no combinational path from commit inputs.
- Record outputs hold stable while `rec_valid & ~rec_ready`.
- `stall` rises the cycle after the push that fills the FIFO, and falls the cycle after the pop that frees an entry.
- `done` rises in the cycle after the edge that pops the HALT record. The DRAIN→DONE transition is evaluated on the registered empty flag.
- `rst` mid-operation discards all FIFO contents and returns every output to its reset value on the next edge.

## Test plan
- Single REG commit: after reset, pc=0x0010, `write_reg`=3, `write_data`=0x1234, `rec_ready`=1. Required: next cycle `rec_valid`=1, kind=1, inum=0, cycle=0, reg=3, rval=0x1234, addr=0, mval=0.
- Classification sweep with `rec_ready`=1:
  - LD r2←[0x0040]=0xBEEF → kind=2, addr=0x0040, rval=0xBEEF.
  - ST [0x0042]=0x0007 → kind=3, reg=0, rval=0.
  - STU → kind=4.
  - Branch with no writes → kind=0.
  - inums 0..3 in order.
- Backpressure with DEPTH=4 and `rec_ready`=0: present 6 back-to-back commits.
  - `stall`=1 after the 4th accept; the 5th is held and not counted.
  - Raise `rec_ready`: records emerge with inums 0..5 strictly in order, no gaps or duplicates.
- Simultaneous push/pop at occupancy 1: occupancy stays 1 and `stall` stays 0.
- Halt drain: HALT accepted with 2 records pending.
  - `stall`=1 from the next cycle; further commits produce no records.
  - HALT record kind=5, inum=2.
  - `done`=1 one cycle after it is popped, and stays 1.
- Reset mid-stream: assert `rst` with 3 records queued.
  - Next cycle `rec_valid`=0, `stall`=0, `done`=0.
  - The following commit yields inum=0, cycle=0.
